// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock time-set path.
// Holds the counter limits, field widths, FSM state encoding and the
// display-highlight codes used by clock_set_ctrl.
package clock_pkg;

  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_e;

  localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;
  localparam logic [SEL_W-1:0] SEL_HOUR = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MIN  = 2'b10;

  // Display highlight for a given state.
  function automatic logic [SEL_W-1:0] sel_decode(input state_e s);
    case (s)
      ST_SET_HOUR: sel_decode = SEL_HOUR;
      ST_SET_MIN:  sel_decode = SEL_MIN;
      default:     sel_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_edge_repeat.sv
// Button front end: 2-flop synchronizer, rising-edge detector and an
// optional hold-to-repeat counter.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   btn_i   - raw asynchronous button level
//   press_c - one-cycle press pulse (combinational from registered state)
module button_edge_repeat #(
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_c
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level, rise, held, rep;

  assign level = sync_q[1];
  assign rise  = level & ~prev_q;
  assign held  = level & prev_q;

  // Synchronizer, edge history and repeat countdown.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= level;
      cnt_q  <= cnt_d;
    end
  end

  // Countdown to the next repeat: loaded with the delay on the edge,
  // reloaded with the period each time it fires, cleared on release.
  always_comb begin
    cnt_d = cnt_q;
    rep   = 1'b0;
    if (!REPEAT_EN) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = CNT_W'(REPEAT_DELAY);
    end else if (held) begin
      if (cnt_q == CNT_W'(1)) begin
        rep   = 1'b1;
        cnt_d = CNT_W'(REPEAT_PERIOD);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign press_c = rise | rep;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: turns mode/increment buttons into parallel-load
// strobes for the minute and hour counters, freezing the minute counter
// while the time is edited.
// Ports:
//   clock, reset          - clock and asynchronous active-high reset
//   btn_mode, btn_inc     - raw asynchronous buttons
//   count_min, count_hour - current counter values (captured on edit entry)
//   enable_min            - minute counter run enable (RUN only)
//   load_min/data_min     - minute counter load strobe and value
//   load_hour/data_hour   - hour counter load strobe and value
//   edit_sel              - display highlight (00 none, 01 hour, 10 minute)
module clock_set_ctrl #(
  parameter int unsigned MIN_MAX       = clock_pkg::MIN_MAX,
  parameter int unsigned HOUR_MAX      = clock_pkg::HOUR_MAX,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          btn_mode,
  input  logic                          btn_inc,
  input  logic [clock_pkg::MIN_W-1:0]   count_min,
  input  logic [clock_pkg::HOUR_W-1:0]  count_hour,
  output logic                          enable_min,
  output logic                          load_min,
  output logic [clock_pkg::MIN_W-1:0]   data_min,
  output logic                          load_hour,
  output logic [clock_pkg::HOUR_W-1:0]  data_hour,
  output logic [clock_pkg::SEL_W-1:0]   edit_sel
);

  import clock_pkg::*;

  logic mode_press, inc_press;

  button_edge_repeat #(
    .REPEAT_EN     (1'b0),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_mode_btn (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_mode),
    .press_c (mode_press)
  );

  button_edge_repeat #(
    .REPEAT_EN     (1'b1),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_inc_btn (
    .clk_i   (clock),
    .rst_i   (reset),
    .btn_i   (btn_inc),
    .press_c (inc_press)
  );

  state_e              state_q, state_d;
  logic [HOUR_W-1:0]   edit_hour_q, edit_hour_d;
  logic [MIN_W-1:0]    edit_min_q, edit_min_d;
  logic [HOUR_W-1:0]   data_hour_q, data_hour_d;
  logic [MIN_W-1:0]    data_min_q, data_min_d;
  logic                load_q, load_d;
  logic                enable_q, enable_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  // State, edit and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      data_hour_q <= '0;
      data_min_q  <= '0;
      load_q      <= 1'b0;
      enable_q    <= 1'b1;
      sel_q       <= SEL_NONE;
    end else begin
      state_q     <= state_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      data_hour_q <= data_hour_d;
      data_min_q  <= data_min_d;
      load_q      <= load_d;
      enable_q    <= enable_d;
      sel_q       <= sel_d;
    end
  end

  // Next state and edit values; mode is checked first so it wins over inc.
  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          edit_hour_d = (count_hour > HOUR_W'(HOUR_MAX)) ? '0 : count_hour;
          edit_min_d  = (count_min > MIN_W'(MIN_MAX)) ? '0 : count_min;
          state_d     = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (mode_press) begin
          state_d = ST_SET_MIN;
        end else if (inc_press) begin
          edit_hour_d = (edit_hour_q >= HOUR_W'(HOUR_MAX)) ? '0 : edit_hour_q + HOUR_W'(1);
        end
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          state_d = ST_COMMIT;
        end else if (inc_press) begin
          edit_min_d = (edit_min_q >= MIN_W'(MIN_MAX)) ? '0 : edit_min_q + MIN_W'(1);
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    load_d      = (state_d == ST_COMMIT);
    enable_d    = (state_d == ST_RUN);
    sel_d       = sel_decode(state_d);
    data_hour_d = load_d ? edit_hour_d : data_hour_q;
    data_min_d  = load_d ? edit_min_d  : data_min_q;
  end

  assign enable_min = enable_q;
  assign load_min   = load_q;
  assign load_hour  = load_q;
  assign data_min   = data_min_q;
  assign data_hour  = data_hour_q;
  assign edit_sel   = sel_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] count_min = '0;
  logic [4:0] count_hour = '0;
  logic       enable_min, load_min, load_hour;
  logic [5:0] data_min;
  logic [4:0] data_hour;
  logic [1:0] edit_sel;

  clock_set_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .count_min  (count_min),
    .count_hour (count_hour),
    .enable_min (enable_min),
    .load_min   (load_min),
    .data_min   (data_min),
    .load_hour  (load_hour),
    .data_hour  (data_hour),
    .edit_sel   (edit_sel)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0] ch;
    logic [5:0] cm;
    int         nh;
    int         nm;
    logic [4:0] eh;
    logic [5:0] em;
  } vec_t;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   load_cnt = 0;
  bit   post_load = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Raise the selected buttons for 'hold' rising edges, then release for a gap.
  task automatic pulse(input bit do_mode, input bit do_inc, input int hold);
    @(negedge clock);
    if (do_mode) btn_mode = 1'b1;
    if (do_inc)  btn_inc  = 1'b1;
    repeat (hold) @(posedge clock);
    @(negedge clock);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
  endtask

  // Scoreboard: every load cycle pops one expected commit.
  always @(negedge clock) begin
    if (!reset) begin
      if (post_load) begin
        check("enable_after_commit", 32'(enable_min), 32'd1);
        check("load_one_cycle", 32'(load_min), 32'd0);
      end
      post_load = 1'b0;
      if (load_min || load_hour) begin
        load_cnt++;
        post_load = 1'b1;
        check("load_pair", 32'({load_hour, load_min}), 32'd3);
        check("enable_during_load", 32'(enable_min), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_load: got load with h=%0d m=%0d, required none", data_hour, data_min);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("data_hour", 32'(data_hour), 32'(e.h));
          check("data_min", 32'(data_min), 32'(e.m));
        end
      end
    end
  end

  vec_t vecs[6];
  int   loads_before;

  initial begin
    vecs[0] = '{5'd5,  6'd58, 2,  3,  5'd7,  6'd1};
    vecs[1] = '{5'd23, 6'd0,  1,  0,  5'd0,  6'd0};
    vecs[2] = '{5'd30, 6'd63, 0,  0,  5'd0,  6'd0};
    vecs[3] = '{5'd22, 6'd59, 3,  1,  5'd1,  6'd0};
    vecs[4] = '{5'd10, 6'd30, 0,  0,  5'd10, 6'd30};
    vecs[5] = '{5'd0,  6'd5,  24, 60, 5'd0,  6'd5};

    // Reset values and idle behaviour.
    #10 reset = 1'b0;
    @(negedge clock);
    check("rst_enable", 32'(enable_min), 32'd1);
    check("rst_load", 32'({load_hour, load_min}), 32'd0);
    check("rst_data_min", 32'(data_min), 32'd0);
    check("rst_data_hour", 32'(data_hour), 32'd0);
    check("rst_edit_sel", 32'(edit_sel), 32'd0);
    count_hour = 5'd3;
    count_min  = 6'd4;
    repeat (100) @(posedge clock);
    @(negedge clock);
    check("idle_no_loads", 32'(load_cnt), 32'd0);

    // Table-driven full edit sequences.
    for (int i = 0; i < 6; i++) begin
      count_hour = vecs[i].ch;
      count_min  = vecs[i].cm;
      pulse(1'b1, 1'b0, 4);
      check("set_hour_enable", 32'(enable_min), 32'd0);
      check("set_hour_sel", 32'(edit_sel), 32'd1);
      repeat (vecs[i].nh) pulse(1'b0, 1'b1, 4);
      pulse(1'b1, 1'b0, 4);
      check("set_min_sel", 32'(edit_sel), 32'd2);
      check("set_min_enable", 32'(enable_min), 32'd0);
      repeat (vecs[i].nm) pulse(1'b0, 1'b1, 4);
      sb_q.push_back('{vecs[i].eh, vecs[i].em});
      pulse(1'b1, 1'b0, 4);
      check("run_sel", 32'(edit_sel), 32'd0);
      check("run_enable", 32'(enable_min), 32'd1);
    end
    check("vector_loads", 32'(load_cnt), 32'd6);

    // Auto-repeat: 30 held cycles -> edge + repeats at +8,+12,...,+28 = 7.
    count_hour = 5'd0;
    count_min  = 6'd0;
    pulse(1'b1, 1'b0, 4);
    pulse(1'b1, 1'b0, 4);
    pulse(1'b0, 1'b1, 30);
    repeat (10) @(posedge clock);
    sb_q.push_back('{5'd0, 6'd7});
    pulse(1'b1, 1'b0, 4);

    // Simultaneous mode+inc in SET_HOUR: mode wins, hour unchanged.
    count_hour = 5'd4;
    count_min  = 6'd10;
    pulse(1'b1, 1'b0, 4);
    pulse(1'b1, 1'b1, 4);
    check("simul_sel", 32'(edit_sel), 32'd2);
    pulse(1'b0, 1'b1, 4);
    sb_q.push_back('{5'd4, 6'd11});
    pulse(1'b1, 1'b0, 4);

    // Held mode gives exactly one transition.
    count_hour = 5'd1;
    count_min  = 6'd2;
    pulse(1'b1, 1'b0, 20);
    check("held_mode_sel", 32'(edit_sel), 32'd1);
    pulse(1'b1, 1'b0, 4);
    sb_q.push_back('{5'd1, 6'd2});
    pulse(1'b1, 1'b0, 4);
    check("all_loads", 32'(load_cnt), 32'd9);

    // Reset mid-edit: back to RUN at once, no load.
    count_hour = 5'd9;
    count_min  = 6'd9;
    pulse(1'b1, 1'b0, 4);
    pulse(1'b1, 1'b0, 4);
    pulse(1'b0, 1'b1, 4);
    loads_before = load_cnt;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_enable", 32'(enable_min), 32'd1);
    check("midrst_sel", 32'(edit_sel), 32'd0);
    check("midrst_load", 32'({load_hour, load_min}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("midrst_no_load", 32'(load_cnt), 32'(loads_before));
    check("midrst_data_min", 32'(data_min), 32'd0);
    check("midrst_sel_after", 32'(edit_sel), 32'd0);

    // Recovery after reset: plain commit of the current counts.
    sb_q.push_back('{5'd9, 6'd9});
    pulse(1'b1, 1'b0, 4);
    pulse(1'b1, 1'b0, 4);
    pulse(1'b1, 1'b0, 4);
    check("final_loads", 32'(load_cnt), 32'(loads_before + 1));
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
